// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with a registered valid/ready handshake, a 2-entry
// skid buffer, synchronous flush and a forwarding view. Optional counters: EX_MEM_STATS_EN.
module ex_mem_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int MEMOP_W = 4
) (
`ifdef EX_MEM_STATS_EN
  output logic [15:0]        stall_cnt_o,
  output logic [15:0]        flush_cnt_o,
`endif
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  ans_i,
  input  logic               we_i,
  input  logic [RADDR_W-1:0] waddr_i,
  input  logic [MEMOP_W-1:0] memop_i,
  input  logic [DATA_W-1:0]  maddr_i,
  input  logic [DATA_W-1:0]  wdata_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  ans_o,
  output logic               we_o,
  output logic [RADDR_W-1:0] waddr_o,
  output logic [MEMOP_W-1:0] memop_o,
  output logic [DATA_W-1:0]  maddr_o,
  output logic [DATA_W-1:0]  wdata_o,
  output logic               fwd_hit_o,
  output logic [DATA_W-1:0]  fwd_data_o
);

  localparam int ENT_W = 3 * DATA_W + 1 + RADDR_W + MEMOP_W;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_SKIDDED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_in_ready;
  logic [ENT_W-1:0] r_main;
  logic [ENT_W-1:0] r_skid;
  logic [ENT_W-1:0] w_in_ent;
  logic             w_out_valid;
  logic             w_acc;
  logic             w_pop;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  logic [DATA_W-1:0]  w_ans;
  logic               w_we;
  logic [RADDR_W-1:0] w_waddr;
  logic [MEMOP_W-1:0] w_memop;
  logic [DATA_W-1:0]  w_maddr;
  logic [DATA_W-1:0]  w_wdata;

  assign w_in_ent    = {ans_i, we_i, waddr_i, memop_i, maddr_i, wdata_i};
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_acc       = in_valid & r_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_acc) begin
          w_state_next   = ST_FULL;
          w_load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_acc && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_acc) begin
          w_state_next = ST_SKIDDED;
          w_load_skid  = 1'b1;
        end else if (w_pop) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_SKIDDED: begin
        if (w_pop) begin
          w_state_next     = ST_FULL;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
    // Flush kills every held entry and any same-cycle accept; data regs keep their bits.
    if (flush) begin
      w_state_next     = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_SKIDDED);
      if (w_load_main_in) begin
        r_main <= w_in_ent;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_ent;
      end
    end
  end

  assign {w_ans, w_we, w_waddr, w_memop, w_maddr, w_wdata} = r_main;

  assign in_ready   = r_in_ready;
  assign out_valid  = w_out_valid;
  assign ans_o      = w_ans;
  assign we_o       = w_we & w_out_valid;
  assign waddr_o    = w_waddr;
  assign memop_o    = w_out_valid ? w_memop : '0;
  assign maddr_o    = w_maddr;
  assign wdata_o    = w_wdata;
  assign fwd_hit_o  = w_out_valid & w_we & (w_waddr != '0);
  assign fwd_data_o = w_ans;

`ifdef EX_MEM_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (flush && w_out_valid && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed vector table, streaming run,
// optional counter checks, then random traffic against a queue-based model.
module tb_ex_mem_pipe_reg;

  logic        clk;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] ans_i, maddr_i, wdata_i, ans_o, maddr_o, wdata_o, fwd_data_o;
  logic        we_i, we_o, fwd_hit_o;
  logic [4:0]  waddr_i, waddr_o;
  logic [3:0]  memop_i, memop_o;
`ifdef EX_MEM_STATS_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_pipe_reg dut (
`ifdef EX_MEM_STATS_EN
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ans_i(ans_i), .we_i(we_i), .waddr_i(waddr_i), .memop_i(memop_i),
    .maddr_i(maddr_i), .wdata_i(wdata_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .ans_o(ans_o), .we_o(we_o), .waddr_o(waddr_o), .memop_o(memop_o),
    .maddr_o(maddr_o), .wdata_o(wdata_o),
    .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] ans;
    logic        we;
    logic [4:0]  waddr;
    logic [3:0]  memop;
    logic [31:0] maddr;
    logic [31:0] wdata;
  } ent_t;

  // Reference: an ordered list of at most two entries, plus the last head shown.
  ent_t m_q[$];
  ent_t m_last;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit   acc, pop;
    ent_t e;
    acc = in_valid && (m_q.size() < 2);
    pop = (m_q.size() > 0) && out_ready;
    e.ans = ans_i; e.we = we_i; e.waddr = waddr_i;
    e.memop = memop_i; e.maddr = maddr_i; e.wdata = wdata_i;
    if (rst) begin
      m_q.delete();
      m_last = '{default: '0};
    end else if (flush) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(e);
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic model_check(input int cyc);
    bit v;
    v = (m_q.size() > 0);
    chk("rnd_out_valid", out_valid, v);
    chk("rnd_in_ready", in_ready, m_q.size() < 2);
    chk("rnd_ans", ans_o, m_last.ans);
    chk("rnd_we", we_o, v && m_last.we);
    chk("rnd_waddr", waddr_o, m_last.waddr);
    chk("rnd_memop", memop_o, v ? m_last.memop : 4'h0);
    chk("rnd_maddr", maddr_o, m_last.maddr);
    chk("rnd_wdata", wdata_o, m_last.wdata);
    chk("rnd_fwd_hit", fwd_hit_o, v && m_last.we && (m_last.waddr != 0));
    chk("rnd_fwd_data", fwd_data_o, m_last.ans);
    if (n_fail > 0 && cyc < 0) $display("cycle %0d", cyc);
  endtask

  typedef struct {
    logic        rst, fl, iv, ordy;
    logic [31:0] ans;
    logic        we;
    logic [4:0]  wa;
    logic [3:0]  mop;
    logic        e_ov, e_ir;
    logic [31:0] e_ans;
    logic        e_we;
    logic [3:0]  e_mop;
    logic        e_fwd;
  } vec_t;

  vec_t tbl[20];

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0;
    ans_i = 0; we_i = 0; waddr_i = 0; memop_i = 0; maddr_i = 0; wdata_i = 0;
    m_last = '{default: '0};

    //          rst fl iv or  ans            we wa    mop   ov ir e_ans          we mop   fwd
    tbl[0]  = '{1, 0, 0, 0, 32'h0,          0, 5'd0, 4'h0, 0, 1, 32'h0,          0, 4'h0, 0};
    tbl[1]  = '{1, 0, 0, 0, 32'h0,          0, 5'd0, 4'h0, 0, 1, 32'h0,          0, 4'h0, 0};
    tbl[2]  = '{0, 0, 1, 1, 32'h1234_5678,  1, 5'd3, 4'h0, 1, 1, 32'h1234_5678,  1, 4'h0, 1};
    tbl[3]  = '{0, 0, 0, 1, 32'h0,          0, 5'd0, 4'h0, 0, 1, 32'h1234_5678,  0, 4'h0, 0};
    tbl[4]  = '{0, 0, 1, 0, 32'hA,          0, 5'd0, 4'h0, 1, 1, 32'hA,          0, 4'h0, 0};
    tbl[5]  = '{0, 0, 1, 0, 32'hB,          0, 5'd0, 4'h0, 1, 0, 32'hA,          0, 4'h0, 0};
    tbl[6]  = '{0, 0, 1, 0, 32'hC,          0, 5'd0, 4'h0, 1, 0, 32'hA,          0, 4'h0, 0};
    tbl[7]  = '{0, 0, 0, 1, 32'h0,          0, 5'd0, 4'h0, 1, 1, 32'hB,          0, 4'h0, 0};
    tbl[8]  = '{0, 0, 0, 1, 32'h0,          0, 5'd0, 4'h0, 0, 1, 32'hB,          0, 4'h0, 0};
    tbl[9]  = '{0, 0, 1, 0, 32'hD,          1, 5'd7, 4'h3, 1, 1, 32'hD,          1, 4'h3, 1};
    tbl[10] = '{0, 0, 1, 0, 32'hE,          1, 5'd8, 4'h1, 1, 0, 32'hD,          1, 4'h3, 1};
    tbl[11] = '{0, 1, 1, 0, 32'hC,          1, 5'd1, 4'h1, 0, 1, 32'hD,          0, 4'h0, 0};
    tbl[12] = '{0, 0, 0, 1, 32'h0,          0, 5'd0, 4'h0, 0, 1, 32'hD,          0, 4'h0, 0};
    tbl[13] = '{0, 0, 1, 0, 32'h55,         1, 5'd0, 4'h0, 1, 1, 32'h55,         1, 4'h0, 0};
    tbl[14] = '{0, 0, 1, 1, 32'h66,         0, 5'd0, 4'h2, 1, 1, 32'h66,         0, 4'h2, 0};
    tbl[15] = '{0, 0, 0, 1, 32'h0,          0, 5'd0, 4'h0, 0, 1, 32'h66,         0, 4'h0, 0};
    tbl[16] = '{0, 0, 1, 0, 32'h77,         1, 5'd9, 4'h0, 1, 1, 32'h77,         1, 4'h0, 1};
    tbl[17] = '{0, 1, 1, 1, 32'h88,         1, 5'd9, 4'h0, 0, 1, 32'h77,         0, 4'h0, 0};
    tbl[18] = '{0, 0, 1, 0, 32'h99,         1, 5'd2, 4'h0, 1, 1, 32'h99,         1, 4'h0, 1};
    tbl[19] = '{1, 1, 1, 0, 32'hAA,         1, 5'd2, 4'h5, 0, 1, 32'h0,          0, 4'h0, 0};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; flush = tbl[i].fl; in_valid = tbl[i].iv; out_ready = tbl[i].ordy;
      ans_i = tbl[i].ans; we_i = tbl[i].we; waddr_i = tbl[i].wa; memop_i = tbl[i].mop;
      maddr_i = tbl[i].ans + 32'd1; wdata_i = ~tbl[i].ans;
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chk($sformatf("vec%0d_ans", i), ans_o, tbl[i].e_ans);
      chk($sformatf("vec%0d_we", i), we_o, tbl[i].e_we);
      chk($sformatf("vec%0d_memop", i), memop_o, tbl[i].e_mop);
      chk($sformatf("vec%0d_fwd_hit", i), fwd_hit_o, tbl[i].e_fwd);
      $display("vec %0d ov=%0b ir=%0b ans=%0h", i, out_valid, in_ready, ans_o);
    end
    rst = 0; flush = 0;

    // Back-to-back streaming: one result per cycle, no back-pressure.
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1; out_ready = 1; ans_i = k; we_i = 0; memop_i = 0;
      tick();
      chk($sformatf("stream%0d_ans", k), ans_o, k);
      chk($sformatf("stream%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("stream%0d_ready", k), in_ready, 1'b1);
      $display("stream %0d ans=%0h", k, ans_o);
    end
    in_valid = 0;
    tick();
    chk("stream_drain", out_valid, 1'b0);

`ifdef EX_MEM_STATS_EN
    rst = 1; tick(); rst = 0;
    in_valid = 1; out_ready = 0; ans_i = 32'h5;
    tick();
    in_valid = 0;
    for (int k = 0; k < 5; k++) tick();
    chk("stats_stall5", stall_cnt_o, 16'd5);
    flush = 1; tick(); flush = 0;
    in_valid = 1; tick(); in_valid = 0;
    flush = 1; tick();
    tick();
    flush = 0;
    chk("stats_flush2", flush_cnt_o, 16'd2);
    $display("stats stall=%0d flush=%0d", stall_cnt_o, flush_cnt_o);
    rst = 1; tick(); rst = 0;
    chk("stats_rst_stall", stall_cnt_o, 16'd0);
    chk("stats_rst_flush", flush_cnt_o, 16'd0);
`endif

    // Random traffic against the queue model.
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      ans_i     = $urandom;
      we_i      = $urandom_range(0, 1);
      waddr_i   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      memop_i   = 4'($urandom);
      maddr_i   = $urandom;
      wdata_i   = $urandom;
      tick();
      model_check(c);
      if (c % 100 == 0)
        $display("rnd %0d ov=%0b ir=%0b ans=%0h q=%0d", c, out_valid, in_ready, ans_o, m_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
